// File: rtl/parity_frame_checker_pkg.sv
// ============================================================================
//  Package : parity_pkg
//  Shared state encoding and default sizing for the parity frame checker.
//  Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package parity_pkg;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_REPORT  = 1'b1
  } pchk_state_t;

  localparam int FRAME_LEN_DEFAULT = 8;
  localparam int CNT_W_DEFAULT     = 16;

endpackage

`default_nettype wire

// File: rtl/parity_frame_checker_nibble_parity.sv
// ============================================================================
//  Module  : nibble_parity
//  Combinational XOR reduction of a 4-bit nibble.
//  Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module nibble_parity (
  input  logic [3:0] a,
  output logic       y
);

  assign y = ^a;

endmodule

`default_nettype wire

// File: rtl/parity_frame_checker.sv
// ============================================================================
//  Module  : parity_frame_checker
//  Groups nibble+parity beats into frames and emits one parity verdict per frame.
//  Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module parity_frame_checker
  import parity_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DEFAULT,
  parameter bit ODD_PAR   = 1'b0,
  parameter int CNT_W     = CNT_W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           in_data,
  input  logic                 in_par,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_ok,
  output logic [FRAME_LEN-1:0] out_err_mask,
  output logic [CNT_W-1:0]     err_count
);

  localparam int                 c_IDX_W    = $clog2(FRAME_LEN);
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(FRAME_LEN - 1);

  pchk_state_t            r_state;
  logic [c_IDX_W-1:0]     r_beat_idx;
  logic [FRAME_LEN-1:0]   r_mask;
  logic                   r_in_ready;
  logic                   r_out_valid;
  logic                   r_out_ok;
  logic [FRAME_LEN-1:0]   r_out_err_mask;
  logic [CNT_W-1:0]       r_err_count;

  logic                   w_par;
  logic                   w_fail;
  logic [FRAME_LEN-1:0]   w_mask_next;
  logic                   w_cnt_sat;

  nibble_parity u_nibble_parity (
    .a (in_data),
    .y (w_par)
  );

  assign w_fail      = w_par ^ in_par ^ ODD_PAR;
  assign w_mask_next = r_mask | (FRAME_LEN'(w_fail) << r_beat_idx);
  assign w_cnt_sat   = &r_err_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_COLLECT;
      r_beat_idx     <= '0;
      r_mask         <= '0;
      r_in_ready     <= 1'b1;
      r_out_valid    <= 1'b0;
      r_out_ok       <= 1'b0;
      r_out_err_mask <= '0;
      r_err_count    <= '0;
    end else begin
      case (r_state)
        ST_COLLECT: begin
          // Flush wins over a beat offered in the same cycle; the beat is lost.
          if (flush) begin
            r_beat_idx <= '0;
            r_mask     <= '0;
          end else if (in_valid) begin
            r_mask <= w_mask_next;
            if (w_fail && !w_cnt_sat) begin
              r_err_count <= r_err_count + CNT_W'(1);
            end
            if (r_beat_idx == c_LAST_IDX) begin
              r_beat_idx     <= '0;
              r_state        <= ST_REPORT;
              r_in_ready     <= 1'b0;
              r_out_valid    <= 1'b1;
              r_out_ok       <= (w_mask_next == '0);
              r_out_err_mask <= w_mask_next;
            end else begin
              r_beat_idx <= r_beat_idx + c_IDX_W'(1);
            end
          end
        end
        ST_REPORT: begin
          if (out_ready) begin
            r_mask         <= '0;
            r_state        <= ST_COLLECT;
            r_in_ready     <= 1'b1;
            r_out_valid    <= 1'b0;
            r_out_ok       <= 1'b0;
            r_out_err_mask <= '0;
          end
        end
        default: r_state <= ST_COLLECT;
      endcase
    end
  end

  assign in_ready     = r_in_ready;
  assign out_valid    = r_out_valid;
  assign out_ok       = r_out_ok;
  assign out_err_mask = r_out_err_mask;
  assign err_count    = r_err_count;

endmodule

`default_nettype wire

// File: tb/tb_parity_frame_checker.sv
// ============================================================================
//  Module  : tb_parity_frame_checker
//  Scoreboard bench for parity_frame_checker (default, odd-parity, narrow-count).
//  Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_parity_frame_checker;

  typedef struct packed {
    logic        ok;
    logic [7:0]  mask;
    logic [15:0] cnt;
  } verdict_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = 4'h0;
  logic       in_par = 1'b0;
  logic       out_ready = 1'b1;

  logic        a_ready, a_valid, a_ok;
  logic [7:0]  a_mask;
  logic [15:0] a_cnt;
  logic        b_ready, b_valid, b_ok;
  logic [7:0]  b_mask;
  logic [15:0] b_cnt;
  logic        c_ready, c_valid, c_ok;
  logic [7:0]  c_mask;
  logic [1:0]  c_cnt;

  int sel = 0;
  logic        obs_ready, obs_valid, obs_ok;
  logic [7:0]  obs_mask;
  logic [15:0] obs_cnt;

  verdict_t   sb_q[$];
  verdict_t   exp_v;
  logic [7:0] m_mask;
  int         m_idx, m_cnt, m_cmax;
  logic       m_odd;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  parity_frame_checker #(.FRAME_LEN(8), .ODD_PAR(1'b0), .CNT_W(16)) u_dut_a (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(a_ready),
    .in_data(in_data), .in_par(in_par), .out_valid(a_valid), .out_ready(out_ready),
    .out_ok(a_ok), .out_err_mask(a_mask), .err_count(a_cnt));

  parity_frame_checker #(.FRAME_LEN(8), .ODD_PAR(1'b1), .CNT_W(16)) u_dut_b (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(b_ready),
    .in_data(in_data), .in_par(in_par), .out_valid(b_valid), .out_ready(out_ready),
    .out_ok(b_ok), .out_err_mask(b_mask), .err_count(b_cnt));

  parity_frame_checker #(.FRAME_LEN(8), .ODD_PAR(1'b0), .CNT_W(2)) u_dut_c (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(c_ready),
    .in_data(in_data), .in_par(in_par), .out_valid(c_valid), .out_ready(out_ready),
    .out_ok(c_ok), .out_err_mask(c_mask), .err_count(c_cnt));

  assign obs_ready = (sel == 0) ? a_ready : (sel == 1) ? b_ready : c_ready;
  assign obs_valid = (sel == 0) ? a_valid : (sel == 1) ? b_valid : c_valid;
  assign obs_ok    = (sel == 0) ? a_ok    : (sel == 1) ? b_ok    : c_ok;
  assign obs_mask  = (sel == 0) ? a_mask  : (sel == 1) ? b_mask  : c_mask;
  assign obs_cnt   = (sel == 0) ? a_cnt   : (sel == 1) ? b_cnt   : {14'd0, c_cnt};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int which);
    sel = which;
    m_odd  = (which == 1);
    m_cmax = (which == 2) ? 3 : 65535;
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0;
    step(); step();
    reset = 1'b0;
    m_mask = '0; m_idx = 0; m_cnt = 0;
    sb_q.delete();
  endtask

  task automatic model_accept(input logic [3:0] d, input logic p);
    logic fail;
    fail = p ^ (^d) ^ m_odd;
    if (fail) begin
      m_mask[m_idx] = 1'b1;
      if (m_cnt < m_cmax) m_cnt++;
    end
    if (m_idx == 7) begin
      sb_q.push_back('{ok: (m_mask == 8'h00), mask: m_mask, cnt: 16'(m_cnt)});
      m_mask = '0;
      m_idx  = 0;
    end else begin
      m_idx++;
    end
  endtask

  task automatic send_beat(input logic [3:0] d, input logic p);
    int budget;
    budget = 0;
    in_valid = 1'b1; in_data = d; in_par = p;
    while (!obs_ready && budget < 20) begin
      step();
      budget++;
    end
    if (!obs_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL beat_accept: in_ready stayed %b, required 1", obs_ready);
    end else begin
      step();
      model_accept(d, p);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(0);
    n_cmp++; if (obs_ready !== 1'b1)  begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", obs_ready); end
    n_cmp++; if (obs_valid !== 1'b0)  begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", obs_valid); end
    n_cmp++; if (obs_ok !== 1'b0)     begin n_bad++; $display("FAIL reset_out_ok: got %b want 0", obs_ok); end
    n_cmp++; if (obs_mask !== 8'h00)  begin n_bad++; $display("FAIL reset_mask: got %h want 00", obs_mask); end
    n_cmp++; if (obs_cnt !== 16'd0)   begin n_bad++; $display("FAIL reset_count: got %0d want 0", obs_cnt); end
  endtask

  task automatic test_clean_frame();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) send_beat(4'h0, 1'b0);
    n_cmp++; if (obs_valid !== 1'b1) begin n_bad++; $display("FAIL clean_valid_latency: got %b want 1", obs_valid); end
    n_cmp++; if (obs_ready !== 1'b0) begin n_bad++; $display("FAIL clean_ready_low: got %b want 0", obs_ready); end
    exp_v = sb_q.pop_front();
    n_cmp++; if (obs_ok !== exp_v.ok)     begin n_bad++; $display("FAIL clean_ok: got %b want %b", obs_ok, exp_v.ok); end
    n_cmp++; if (obs_mask !== exp_v.mask) begin n_bad++; $display("FAIL clean_mask: got %h want %h", obs_mask, exp_v.mask); end
    n_cmp++; if (obs_cnt !== exp_v.cnt)   begin n_bad++; $display("FAIL clean_count: got %0d want %0d", obs_cnt, exp_v.cnt); end
    step();
    n_cmp++; if (obs_valid !== 1'b0) begin n_bad++; $display("FAIL clean_valid_drop: got %b want 0", obs_valid); end
    n_cmp++; if (obs_ready !== 1'b1) begin n_bad++; $display("FAIL clean_ready_back: got %b want 1", obs_ready); end
  endtask

  task automatic test_error_frame();
    logic [3:0] d;
    for (int i = 0; i < 8; i++) begin
      d = 4'(i + 3);
      if (i == 2 || i == 5) send_beat(4'h7, 1'b0);
      else send_beat(d, ^d);
    end
    exp_v = sb_q.pop_front();
    n_cmp++; if (obs_valid !== 1'b1)      begin n_bad++; $display("FAIL err_valid: got %b want 1", obs_valid); end
    n_cmp++; if (obs_ok !== exp_v.ok)     begin n_bad++; $display("FAIL err_ok: got %b want %b", obs_ok, exp_v.ok); end
    n_cmp++; if (obs_mask !== exp_v.mask) begin n_bad++; $display("FAIL err_mask: got %h want %h", obs_mask, exp_v.mask); end
    n_cmp++; if (obs_cnt !== exp_v.cnt)   begin n_bad++; $display("FAIL err_count: got %0d want %0d", obs_cnt, exp_v.cnt); end
    step();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send_beat(4'(i), (i == 7) ? ~(^4'(i)) : ^4'(i));
    exp_v = sb_q.pop_front();
    in_valid = 1'b1; in_data = 4'h1; in_par = 1'b0;
    for (int k = 0; k < 5; k++) begin
      n_cmp++; if (obs_ready !== 1'b0)      begin n_bad++; $display("FAIL bp_ready[%0d]: got %b want 0", k, obs_ready); end
      n_cmp++; if (obs_valid !== 1'b1)      begin n_bad++; $display("FAIL bp_valid[%0d]: got %b want 1", k, obs_valid); end
      n_cmp++; if (obs_mask !== exp_v.mask) begin n_bad++; $display("FAIL bp_mask[%0d]: got %h want %h", k, obs_mask, exp_v.mask); end
      step();
    end
    n_cmp++; if (obs_cnt !== exp_v.cnt) begin n_bad++; $display("FAIL bp_count_held: got %0d want %0d", obs_cnt, exp_v.cnt); end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    n_cmp++; if (obs_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_release: got %b want 1", obs_ready); end
    n_cmp++; if (obs_valid !== 1'b0) begin n_bad++; $display("FAIL bp_valid_release: got %b want 0", obs_valid); end
  endtask

  task automatic test_flush();
    send_beat(4'h0, 1'b0);
    send_beat(4'h1, 1'b0);
    send_beat(4'h3, 1'b0);
    flush = 1'b1; in_valid = 1'b1; in_data = 4'h1; in_par = 1'b0;
    step();
    flush = 1'b0; in_valid = 1'b0;
    m_mask = '0; m_idx = 0;
    n_cmp++; if (obs_cnt !== 16'(m_cnt)) begin n_bad++; $display("FAIL flush_count: got %0d want %0d", obs_cnt, m_cnt); end
    send_beat(4'h2, 1'b0);
    for (int i = 1; i < 8; i++) send_beat(4'h0, 1'b0);
    exp_v = sb_q.pop_front();
    n_cmp++; if (obs_valid !== 1'b1)      begin n_bad++; $display("FAIL flush_valid: got %b want 1", obs_valid); end
    n_cmp++; if (obs_mask !== exp_v.mask) begin n_bad++; $display("FAIL flush_mask: got %h want %h", obs_mask, exp_v.mask); end
    n_cmp++; if (obs_cnt !== exp_v.cnt)   begin n_bad++; $display("FAIL flush_frame_count: got %0d want %0d", obs_cnt, exp_v.cnt); end
    step();
  endtask

  task automatic test_odd_parity();
    do_reset(1);
    out_ready = 1'b1;
    send_beat(4'h3, 1'b1);
    send_beat(4'h3, 1'b0);
    for (int i = 2; i < 8; i++) send_beat(4'h0, 1'b1);
    exp_v = sb_q.pop_front();
    n_cmp++; if (obs_ok !== exp_v.ok)     begin n_bad++; $display("FAIL odd_ok: got %b want %b", obs_ok, exp_v.ok); end
    n_cmp++; if (obs_mask !== exp_v.mask) begin n_bad++; $display("FAIL odd_mask: got %h want %h", obs_mask, exp_v.mask); end
    n_cmp++; if (obs_cnt !== exp_v.cnt)   begin n_bad++; $display("FAIL odd_count: got %0d want %0d", obs_cnt, exp_v.cnt); end
    step();
  endtask

  task automatic test_saturation();
    do_reset(2);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send_beat(4'h1, 1'b0);
      n_cmp++; if (obs_cnt !== 16'(m_cnt)) begin n_bad++; $display("FAIL sat_count[%0d]: got %0d want %0d", i, obs_cnt, m_cnt); end
    end
    for (int i = 5; i < 8; i++) send_beat(4'h0, 1'b0);
    exp_v = sb_q.pop_front();
    n_cmp++; if (obs_mask !== exp_v.mask) begin n_bad++; $display("FAIL sat_mask: got %h want %h", obs_mask, exp_v.mask); end
    n_cmp++; if (obs_cnt !== exp_v.cnt)   begin n_bad++; $display("FAIL sat_final: got %0d want %0d", obs_cnt, exp_v.cnt); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_cmp++; if (obs_valid !== 1'b0) begin n_bad++; $display("FAIL report_reset_valid: got %b want 0", obs_valid); end
    n_cmp++; if (obs_ready !== 1'b1) begin n_bad++; $display("FAIL report_reset_ready: got %b want 1", obs_ready); end
    n_cmp++; if (obs_cnt !== 16'd0)  begin n_bad++; $display("FAIL report_reset_count: got %0d want 0", obs_cnt); end
    out_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_clean_frame();
    test_error_frame();
    test_backpressure();
    test_flush();
    test_odd_parity();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
